alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Multi-cycle instruction sequencer that drives the datapath ALU's (opcode, X, Y) interface and consumes its (result, zero) outputs.
- Accepts 16-bit instructions via valid/ready, decodes to the 3-bit ALU opcode, reads operands from an internal 8x16 register file, captures the ALU response, writes back, and reports status.
- Sits between instruction source (testbench/fetch) and the combinational ALU; the ALU itself is external.

Parameters:
DATA_W, 16, operand/result width (fixed by instruction format; only 16 supported)
ALU_OP_W, 3, ALU opcode width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept instruction (high only in IDLE)
instr  input  16  instruction word
alu_op  output  3  opcode to ALU (registered)
alu_x  output  16  operand X to ALU (registered)
alu_y  output  16  operand Y to ALU (registered)
alu_out  input  16  ALU result (combinational from alu_op/x/y)
alu_zero  input  1  ALU zero flag
done  output  1  one-cycle pulse, instruction retired
result  output  16  captured ALU result of last instruction
taken  output  1  BEQ outcome, valid when done
err  output  1  sticky illegal-op flag (see optional feature)
dbg_addr  input  3  debug register read address
dbg_data  output  16  combinational read of reg[dbg_addr]

Behaviour:
- Clock/reset: one clock; reset asynchronous, active-high. Reset -> state IDLE, all 8 regs = 0, alu_op/alu_x/alu_y = 0, result = 0, done = 0, taken = 0, err = 0. Reset mid-instruction aborts it; no writeback.
- Instruction format: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored. LI: [12:10] rd, [9:0] imm10 zero-extended.
- Op map (op -> alu_op, X, Y, writeback): 000 AND -> 000,rs,rt,yes; 001 OR -> 001,rs,rt,yes; 010 ADD -> 010,rs,rt,yes; 011 SUB -> 110,rs,rt,yes; 100 SLT -> 111,rs,rt,yes; 101 BEQ -> 110,rs,rt,no; 110 LI -> 010,0,imm10,yes; 111 illegal -> no ALU issue, no writeback.
- r0 reads as 0; writes to r0 discarded.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1; on instr_valid at edge, latch instr.
  - DECODE: read rs/rt; at edge register alu_op/alu_x/alu_y.
  - EXEC: ALU settles; at edge capture alu_out into result and alu_zero into a zero register.
  - WB: done=1, taken = (op==BEQ) & captured zero, else 0; at WB-exiting edge write result to rd if writeback.
- Latency: accept edge to done high = 3 cycles; throughput 1 instr / 4 cycles. instr_valid outside IDLE is ignored (no ready).
- alu_op/x/y hold values until next DECODE.
- Arithmetic is the ALU's: 16-bit wrap, SLT unsigned; this block adds nothing.
- Illegal op: passes DECODE/EXEC without changing alu_* or result; done still pulses in WB; taken=0.
- dbg_data reflects register contents after the WB edge; reading r0 returns 0.

Optional Feature:
ALU_ISSUE_TRAP_EN
- Defined: op 111 sets err=1 at the WB edge; err sticky until reset; instructions continue executing normally.
- Undefined: op 111 is a silent NOP; err tied 0.

Test Plan:
- Reset then idle: reset pulse -> instr_ready=1, done=0, err=0, dbg_data=0 for all 8 addresses.
- LI 16'hC405, LI 16'hC803, ADD 16'h4CA0 -> each done 3 cycles after accept; final result=8; dbg r1=5, r2=3, r3=8; ADD alu_op=010.
- SUB 16'h7110 (r4=r2-r1) -> alu_op=110, result=16'hFFFE, r4=16'hFFFE; BEQ 16'hA090 (r1,r1) -> taken=1 for one cycle, no register changed.
- Write to r0: LI 16'hC07F -> result=16'h007F, dbg r0 still 0; instr_valid held high during DECODE -> no second accept.
- Assert reset in EXEC of ADD into r3 -> r3=0, done never pulses, instr_ready=1 on the cycle after reset deasserts.
- Op 16'hE000 -> with ALU_ISSUE_TRAP_EN err=1 and stays 1 across later instructions; without it err=0; done pulses in both cases.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer: accepts one instruction, drives an external ALU, writes back to an 8x16 register file.
// Optional feature macro ALU_ISSUE_TRAP_EN: op 111 raises a sticky err flag instead of being a silent NOP.
module alu_issue_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [15:0]         instr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_zero,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                taken,
    output logic                err,
    input  logic [2:0]          dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b101;
    localparam logic [2:0] OP_LI  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       instr_p0;
    logic              zero_p2;
    logic [DATA_W-1:0] regs [8];

    logic [2:0]        f_op, f_rd, f_rs, f_rt;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              is_legal, is_beq, writes_back;

    // Translate instruction op to the ALU's own opcode encoding.
    function automatic logic [ALU_OP_W-1:0] map_alu_op(input logic [2:0] op);
        logic [ALU_OP_W-1:0] code;
        case (op)
            OP_AND:  code = ALU_OP_W'(3'b000);
            OP_OR:   code = ALU_OP_W'(3'b001);
            OP_ADD:  code = ALU_OP_W'(3'b010);
            OP_SUB:  code = ALU_OP_W'(3'b110);
            OP_SLT:  code = ALU_OP_W'(3'b111);
            OP_BEQ:  code = ALU_OP_W'(3'b110);
            OP_LI:   code = ALU_OP_W'(3'b010);
            default: code = ALU_OP_W'(3'b000);
        endcase
        return code;
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] addr,
                                                   input logic [DATA_W-1:0] value);
        return (addr == 3'd0) ? '0 : value;
    endfunction

    assign f_op    = instr_p0[15:13];
    assign f_rd    = instr_p0[12:10];
    assign f_rs    = instr_p0[9:7];
    assign f_rt    = instr_p0[6:4];
    assign imm_ext = {{(DATA_W-10){1'b0}}, instr_p0[9:0]};

    assign is_legal    = (f_op != OP_ILL);
    assign is_beq      = (f_op == OP_BEQ);
    assign writes_back = is_legal && !is_beq;

    assign rs_val   = read_reg(f_rs, regs[f_rs]);
    assign rt_val   = read_reg(f_rt, regs[f_rt]);
    assign dbg_data = read_reg(dbg_addr, regs[dbg_addr]);

    assign instr_ready = (state == IDLE);
    assign done        = (state == WB);
    assign taken       = (state == WB) && is_beq && zero_p2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage 0: latch the accepted instruction word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_p0 <= '0;
        end else if (state == IDLE && instr_valid) begin
            instr_p0 <= instr;
        end
    end

    // Stage 1: issue operands to the ALU; they hold until the next legal decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op <= '0;
            alu_x  <= '0;
            alu_y  <= '0;
        end else if (state == DECODE && is_legal) begin
            alu_op <= map_alu_op(f_op);
            alu_x  <= (f_op == OP_LI) ? '0 : rs_val;
            alu_y  <= (f_op == OP_LI) ? imm_ext : rt_val;
        end
    end

    // Stage 2: capture the settled ALU response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result  <= '0;
            zero_p2 <= 1'b0;
        end else if (state == EXEC && is_legal) begin
            result  <= alu_out;
            zero_p2 <= alu_zero;
        end
    end

    // Stage 3: write back on the edge leaving WB; r0 is never written so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (state == WB && writes_back && f_rd != 3'd0) begin
            regs[f_rd] <= result;
        end
    end

`ifdef ALU_ISSUE_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == WB && !is_legal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
